// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg: funct3 codes, FSM encodings and memory-window defaults      |
// | shared by the load/store unit.           Revision: 1.0                |
// +----------------------------------------------------------------------+
package mem_pkg;

   localparam logic [31:0] BASE_WORD_DEF   = 32'hC00;
   localparam int unsigned DEPTH_WORDS_DEF = 256;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store)
         return !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
      return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lsu_align: byte/half lane extract+extend for loads and lane      |
// | merge for sub-word stores.               Revision: 1.0                |
// +----------------------------------------------------------------------+
module mem_lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_byte_sel;
   logic [15:0] w_half_sel;

   always_comb begin
      w_byte_sel = i_word[7:0];
      case (i_offset)
         2'd1:    w_byte_sel = i_word[15:8];
         2'd2:    w_byte_sel = i_word[23:16];
         2'd3:    w_byte_sel = i_word[31:24];
         default: w_byte_sel = i_word[7:0];
      endcase
      w_half_sel = i_offset[1] ? i_word[31:16] : i_word[15:0];
   end

   always_comb begin
      o_load_data = i_word;
      case (i_funct3)
         F3_LB:   o_load_data = {{24{w_byte_sel[7]}}, w_byte_sel};
         F3_LBU:  o_load_data = {24'h0, w_byte_sel};
         F3_LH:   o_load_data = {{16{w_half_sel[15]}}, w_half_sel};
         F3_LHU:  o_load_data = {16'h0, w_half_sel};
         default: o_load_data = i_word;
      endcase
   end

   // Untouched lanes keep the word read back during RMW_RD.
   always_comb begin
      o_store_word = i_word;
      case (i_funct3[1:0])
         2'b00: begin
            case (i_offset)
               2'd0:    o_store_word[7:0]   = i_wdata[7:0];
               2'd1:    o_store_word[15:8]  = i_wdata[7:0];
               2'd2:    o_store_word[23:16] = i_wdata[7:0];
               default: o_store_word[31:24] = i_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (i_offset[1])
               o_store_word[31:16] = i_wdata[15:0];
            else
               o_store_word[15:0]  = i_wdata[15:0];
         end
         default: o_store_word = i_wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lsu: RV32I load/store unit for a word-organised data memory,     |
// | with read-modify-write for SB/SH.        Revision: 1.0                |
// +----------------------------------------------------------------------+
module mem_lsu
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_WORD   = BASE_WORD_DEF,
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_store,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_mem_memread,
   output logic        o_mem_memwrite,
   output logic [31:0] o_mem_address,
   output logic [31:0] o_mem_write_data,
   input  logic [31:0] i_mem_read_data
);

   localparam logic [31:0] END_WORD = BASE_WORD + DEPTH_WORDS;

   logic [2:0]  state_q,  state_d;
   logic        store_q,  store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [31:0] merge_q,  merge_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        err_q,    err_d;

   logic [31:0] w_word_idx;
   logic        w_misalign;
   logic        w_out_range;
   logic        w_req_err;
   logic [31:0] w_align_word;
   logic [31:0] w_load_data;
   logic [31:0] w_store_word;
   logic        w_mem_active;

   assign w_word_idx  = {2'b00, i_req_addr[31:2]};
   assign w_out_range = (w_word_idx < BASE_WORD) || (w_word_idx >= END_WORD);
   assign w_misalign  = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0])
                     || ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
   assign w_req_err   = f3_illegal(i_req_store, i_req_funct3) || w_misalign || w_out_range;

   // LOAD extracts from the live read data; RMW_WR merges into the captured word.
   assign w_align_word = (state_q == ST_RMW_WR) ? merge_q : i_mem_read_data;

   mem_lsu_align u_align (
      .i_funct3     (funct3_q),
      .i_offset     (addr_q[1:0]),
      .i_word       (w_align_word),
      .i_wdata      (wdata_q),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      merge_d  = merge_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               store_d  = i_req_store;
               funct3_d = i_req_funct3;
               addr_d   = i_req_addr;
               wdata_d  = i_req_wdata;
               if (w_req_err) begin
                  rdata_d = 32'h0;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (!i_req_store)
                  state_d = ST_LOAD;
               else if (i_req_funct3 == F3_SW)
                  state_d = ST_WRITE;
               else
                  state_d = ST_RMW_RD;
            end
         end
         ST_LOAD: begin
            rdata_d = w_load_data;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_RMW_RD: begin
            merge_d = i_mem_read_data;
            state_d = ST_RMW_WR;
         end
         ST_WRITE, ST_RMW_WR: begin
            rdata_d = 32'h0;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         store_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         merge_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merge_q  <= merge_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign w_mem_active = (state_q == ST_LOAD) || (state_q == ST_WRITE)
                      || (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);

   assign o_req_ready      = (state_q == ST_IDLE);
   assign o_rsp_valid      = (state_q == ST_RESP);
   assign o_rsp_rdata      = rdata_q;
   assign o_rsp_err        = err_q;
   assign o_mem_memread    = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
   assign o_mem_memwrite   = (state_q == ST_WRITE) || (state_q == ST_RMW_WR);
   assign o_mem_address    = w_mem_active ? {2'b00, addr_q[31:2]} : 32'h0;
   assign o_mem_write_data = (state_q == ST_WRITE)  ? wdata_q      :
                             (state_q == ST_RMW_WR) ? w_store_word : 32'h0;

   // store_q is kept for debug visibility of the in-flight request type.
   logic w_unused;
   assign w_unused = store_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_lsu: scoreboard bench for mem_lsu with a word memory model.   |
// |                                          Revision: 1.0                |
// +----------------------------------------------------------------------+
module tb_mem_lsu;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_store = 1'b0;
   logic [2:0]  i_req_funct3 = 3'b000;
   logic [31:0] i_req_addr = 32'h0;
   logic [31:0] i_req_wdata = 32'h0;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_mem_memread;
   logic        o_mem_memwrite;
   logic [31:0] o_mem_address;
   logic [31:0] o_mem_write_data;
   logic [31:0] i_mem_read_data;

   mem_lsu u_dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_store      (i_req_store),
      .i_req_funct3     (i_req_funct3),
      .i_req_addr       (i_req_addr),
      .i_req_wdata      (i_req_wdata),
      .o_rsp_valid      (o_rsp_valid),
      .o_rsp_rdata      (o_rsp_rdata),
      .o_rsp_err        (o_rsp_err),
      .o_mem_memread    (o_mem_memread),
      .o_mem_memwrite   (o_mem_memwrite),
      .o_mem_address    (o_mem_address),
      .o_mem_write_data (o_mem_write_data),
      .i_mem_read_data  (i_mem_read_data)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          t0;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          strobe_bad = 0;
   bit          err_window = 1'b0;
   logic [31:0] mem [256];

   always @(posedge i_clk) cyc <= cyc + 1;

   // Memory model: combinational read, write commits on the rising edge.
   always_comb begin
      i_mem_read_data = 32'h0;
      if (o_mem_address >= 32'hC00 && o_mem_address < 32'hD00)
         i_mem_read_data = mem[o_mem_address[7:0]];
   end

   always @(posedge i_clk)
      if (!i_reset && o_mem_memwrite && o_mem_address >= 32'hC00 && o_mem_address < 32'hD00)
         mem[o_mem_address[7:0]] <= o_mem_write_data;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (err_window && (o_mem_memread || o_mem_memwrite))
            strobe_bad++;
         if (o_rsp_valid) begin
            if (sb.size() == 0)
               chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_rdata", o_rsp_rdata, e.rdata);
               chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, e.err});
               chk("rsp_latency", cyc - e.t0, e.lat);
               if (e.err) begin
                  chk("err_no_strobe", strobe_bad, 0);
                  err_window = 1'b0;
               end
            end
         end
      end
   end

   task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input bit want, output int t_acc);
      int guard;
      exp_t e;
      guard = 0;
      @(negedge i_clk);
      while (!o_req_ready && guard < 50) begin
         @(negedge i_clk);
         guard++;
      end
      if (!o_req_ready)
         chk("ready_timeout", 32'd0, 32'd1);
      i_req_valid  = 1'b1;
      i_req_store  = st;
      i_req_funct3 = f3;
      i_req_addr   = a;
      i_req_wdata  = wd;
      t_acc = cyc;
      if (want) begin
         e.rdata = er; e.err = ee; e.lat = lat; e.t0 = cyc;
         sb.push_back(e);
         if (ee) begin
            strobe_bad = 0;
            err_window = 1'b1;
         end
      end
      @(posedge i_clk);
      #1;
      i_req_valid  = 1'b0;
      i_req_store  = 1'($urandom);
      i_req_funct3 = 3'($urandom);
      i_req_addr   = $urandom;
      i_req_wdata  = $urandom;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge i_clk);
         guard++;
      end
      if (sb.size() != 0)
         chk("drain_timeout", sb.size(), 0);
      @(negedge i_clk);
   endtask

   initial begin
      int t1, t2, td;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]   = 32'h80FF7F01;
      mem[1]   = 32'h11223344;
      mem[255] = 32'hCAFED00D;

      repeat (2) @(negedge i_clk);
      chk("rst_ready", {31'h0, o_req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'd0);
      chk("rst_rdata", o_rsp_rdata, 32'h0);
      chk("rst_err", {31'h0, o_rsp_err}, 32'd0);
      chk("rst_memread", {31'h0, o_mem_memread}, 32'd0);
      chk("rst_memwrite", {31'h0, o_mem_memwrite}, 32'd0);
      chk("rst_address", o_mem_address, 32'h0);
      chk("rst_wdata", o_mem_write_data, 32'h0);
      i_reset = 1'b0;

      // Loads of word 0xC00
      send(0, 3'b000, 32'h3001, 0, 32'h0000007F, 0, 2, 1, td);
      send(0, 3'b000, 32'h3003, 0, 32'hFFFFFF80, 0, 2, 1, td);
      send(0, 3'b101, 32'h3002, 0, 32'h000080FF, 0, 2, 1, td);
      send(0, 3'b001, 32'h3002, 0, 32'hFFFF80FF, 0, 2, 1, td);
      send(0, 3'b100, 32'h3003, 0, 32'h00000080, 0, 2, 1, td);
      send(0, 3'b010, 32'h3000, 0, 32'h80FF7F01, 0, 2, 1, td);
      send(0, 3'b010, 32'h33FC, 0, 32'hCAFED00D, 0, 2, 1, td);

      // Sub-word stores via read-modify-write
      send(1, 3'b000, 32'h3005, 32'hDEADBEAB, 32'h0, 0, 3, 1, td);
      drain();
      chk("sb_word", mem[1], 32'h1122AB44);
      send(1, 3'b001, 32'h3006, 32'h0000CAFE, 32'h0, 0, 3, 1, td);
      drain();
      chk("sh_word", mem[1], 32'hCAFEAB44);

      // Error requests
      send(0, 3'b010, 32'h3002, 0, 32'h0, 1, 1, 1, td);
      send(1, 3'b010, 32'h3400, 32'h5555AAAA, 32'h0, 1, 1, 1, td);
      send(1, 3'b001, 32'h3001, 32'h1234, 32'h0, 1, 1, 1, td);
      send(1, 3'b011, 32'h3000, 32'h1, 32'h0, 1, 1, 1, td);
      send(0, 3'b011, 32'h3000, 0, 32'h0, 1, 1, 1, td);
      send(0, 3'b010, 32'h2FFC, 0, 32'h0, 1, 1, 1, td);
      send(0, 3'b000, 32'h3401, 0, 32'h0, 1, 1, 1, td);
      drain();
      chk("err_untouched", mem[0], 32'h80FF7F01);

      // SW then LW to the same word, back to back
      send(1, 3'b010, 32'h30FC, 32'h12345678, 32'h0, 0, 2, 1, t1);
      send(0, 3'b010, 32'h30FC, 0, 32'h12345678, 0, 2, 1, t2);
      chk("sw_lw_gap", t2 - t1, 3);
      drain();
      chk("sw_word", mem[8'h3F], 32'h12345678);
      repeat (2) @(negedge i_clk);
      chk("rsp_hold", o_rsp_rdata, 32'h12345678);

      // Reset during RMW_RD aborts the store
      mem[0] = 32'hAABBCCDD;
      send(1, 3'b000, 32'h3000, 32'h00000011, 32'h0, 0, 3, 0, td);
      chk("rmw_rd_read", {31'h0, o_mem_memread}, 32'd1);
      i_reset = 1'b1;
      #1;
      chk("abort_memwrite", {31'h0, o_mem_memwrite}, 32'd0);
      chk("abort_ready", {31'h0, o_req_ready}, 32'd1);
      @(negedge i_clk);
      i_reset = 1'b0;
      repeat (4) @(negedge i_clk);
      chk("abort_word", mem[0], 32'hAABBCCDD);
      chk("abort_ready_after", {31'h0, o_req_ready}, 32'd1);

      send(0, 3'b010, 32'h3000, 0, 32'hAABBCCDD, 0, 2, 1, td);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
